// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared FSM encodings and owner IDs for the RAM arbiter
package ram_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  function automatic logic [1:0] owner_state(input logic owner);
    return (owner == OWNER_M1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rtl/ram_arbiter_rr_pick.sv - combinational 2-way round-robin grant with burst hold
module ram_arbiter_rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = 2
) (
  input  logic [1:0]    req,
  input  logic [1:0]    state,
  input  logic [CW-1:0] burst_cnt,
  input  logic          rr_owner,
  output logic [1:0]    gnt
);

  logic burst_open;

  assign burst_open = (burst_cnt < CW'(MAX_BURST - 1));

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        case (state)
          ST_OWN0: gnt = burst_open ? 2'b01 : 2'b10;
          ST_OWN1: gnt = burst_open ? 2'b10 : 2'b01;
          default: gnt = (rr_owner == OWNER_M1) ? 2'b10 : 2'b01;
        endcase
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port RAM between the CPU port (m0) and the loader port (m1)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdat,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdat,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdat,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdat,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdat,
  input  logic [DW-1:0] ram_rdat,
  output logic          ram_rd_,
  output logic          ram_wr_
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_TOP = CW'(MAX_BURST - 1);

  logic [1:0]    state;
  logic [CW-1:0] burst_cnt;
  logic          rr_owner;
  logic [1:0]    gnt;
  logic          acc;
  logic          acc_owner;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdat;
  logic          same_owner;
  logic          rd_pend;
  logic          rd_owner;

  ram_arbiter_rr_pick #(
    .MAX_BURST(MAX_BURST),
    .CW       (CW)
  ) u_pick (
    .req      ({m1_req, m0_req}),
    .state    (state),
    .burst_cnt(burst_cnt),
    .rr_owner (rr_owner),
    .gnt      (gnt)
  );

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign acc        = |gnt;
  assign acc_owner  = gnt[1] ? OWNER_M1 : OWNER_M0;
  assign acc_we     = gnt[1] ? m1_we : m0_we;
  assign acc_addr   = gnt[1] ? m1_addr : m0_addr;
  assign acc_wdat   = gnt[1] ? m1_wdat : m0_wdat;
  assign same_owner = (state == ST_OWN0 && gnt[0]) || (state == ST_OWN1 && gnt[1]);

  // rr_owner is the requester favoured on a fresh contention from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      rr_owner  <= OWNER_M0;
    end else if (acc) begin
      state    <= owner_state(acc_owner);
      rr_owner <= ~acc_owner;
      if (!same_owner)
        burst_cnt <= '0;
      else if (burst_cnt != BURST_TOP)
        burst_cnt <= burst_cnt + CW'(1);
    end else begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr <= '0;
      ram_wdat <= '0;
      ram_rd_  <= 1'b1;
      ram_wr_  <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= OWNER_M0;
    end else begin
      ram_rd_ <= ~(acc & ~acc_we);
      ram_wr_ <= ~(acc & acc_we);
      rd_pend <= acc & ~acc_we;
      if (acc) begin
        ram_addr <= acc_addr;
        ram_wdat <= acc_wdat;
        rd_owner <= acc_owner;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdat   <= '0;
      m1_rdat   <= '0;
    end else begin
      m0_rvalid <= rd_pend & (rd_owner == OWNER_M0);
      m1_rvalid <= rd_pend & (rd_owner == OWNER_M1);
      if (rd_pend && rd_owner == OWNER_M0) m0_rdat <= ram_rdat;
      if (rd_pend && rd_owner == OWNER_M1) m1_rdat <= ram_rdat;
    end
  end

  strobe_excl: assert property (@(posedge clk) disable iff (rst) (ram_rd_ || ram_wr_));

endmodule
